// File: rtl/forward_scoreboard_if.sv
// D-stage hazard query bundle: decode drives the instruction fields and pipeline
// controls, the scoreboard answers with per-port forwarding selects and a stall.
interface forward_scoreboard_if #(
  parameter int STAGES = 3,
  parameter int NREAD  = 2
);
  localparam int SW = $clog2(STAGES + 1);

  logic                  valid_D;
  logic [NREAD-1:0]      use_D;
  logic [NREAD*5-1:0]    src_D;
  logic                  wr_D;
  logic [4:0]            dst_D;
  logic [SW-1:0]         avail_D;
  logic                  advance;
  logic                  flush;
  logic [NREAD*SW-1:0]   fwd_sel;
  logic                  stall_D;
  logic [15:0]           stall_cnt;

  modport master (
    output valid_D, use_D, src_D, wr_D, dst_D, avail_D, advance, flush,
    input  fwd_sel, stall_D, stall_cnt
  );

  modport slave (
    input  valid_D, use_D, src_D, wr_D, dst_D, avail_D, advance, flush,
    output fwd_sel, stall_D, stall_cnt
  );
endinterface

// File: rtl/forward_scoreboard.sv
// Operand forwarding / interlock scoreboard: tracks destination registers of the
// instructions in stages 1..STAGES after decode and resolves D-stage source reads.
module forward_scoreboard #(
  parameter int STAGES = 3,
  parameter int NREAD  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  forward_scoreboard_if.slave  bus
);
  localparam int SW = $clog2(STAGES + 1);

  logic [STAGES:1] valid_reg;
  logic [4:0]      dst_reg   [1:STAGES];
  logic [SW-1:0]   avail_reg [1:STAGES];
  logic [15:0]     stall_cnt_reg;

  logic [NREAD-1:0] blocked;
  logic             stall;
  logic             load_d;
  logic [SW-1:0]    avail_norm;

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_port
      logic [4:0]    src;
      logic          hit;
      logic [SW-1:0] hit_stage;
      logic [SW-1:0] hit_avail;

      assign src = bus.src_D[gi*5 +: 5];

      // Scan oldest to youngest so the youngest match overwrites older ones.
      always_comb begin
        hit       = 1'b0;
        hit_stage = '0;
        hit_avail = '0;
        for (int k = STAGES; k >= 1; k--) begin
          if (bus.use_D[gi] && bus.valid_D && valid_reg[k] &&
              (dst_reg[k] == src) && (src != 5'd0)) begin
            hit       = 1'b1;
            hit_stage = SW'(k);
            hit_avail = avail_reg[k];
          end
        end
      end

      assign blocked[gi] = hit && (hit_avail > hit_stage);
      assign bus.fwd_sel[gi*SW +: SW] = (hit && !blocked[gi]) ? hit_stage : '0;
    end
  endgenerate

  // A flushed D instruction never waits on anything.
  assign stall = (|blocked) && !bus.flush;

  assign load_d = bus.valid_D && bus.wr_D && (bus.dst_D != 5'd0) && !stall && !bus.flush;

  // Out-of-range availability is treated as "ready only at the last tracked stage".
  assign avail_norm = ((bus.avail_D == '0) || (32'(bus.avail_D) > STAGES)) ?
                      SW'(STAGES) : bus.avail_D;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        dst_reg[k]   <= '0;
        avail_reg[k] <= '0;
      end
    end else if (bus.advance) begin
      for (int k = STAGES; k >= 2; k--) begin
        valid_reg[k] <= valid_reg[k-1];
        dst_reg[k]   <= dst_reg[k-1];
        avail_reg[k] <= avail_reg[k-1];
      end
      valid_reg[1] <= load_d;
      dst_reg[1]   <= load_d ? bus.dst_D : 5'd0;
      avail_reg[1] <= load_d ? avail_norm : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (bus.advance && stall && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign bus.stall_D   = stall;
  assign bus.stall_cnt = stall_cnt_reg;
endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed hazard scenarios plus random traffic
// compared against a list-of-producers pipeline model.
module tb_forward_scoreboard;
  localparam int STAGES = 3;
  localparam int NREAD  = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  forward_scoreboard_if #(.STAGES(STAGES), .NREAD(NREAD)) bus ();

  forward_scoreboard #(.STAGES(STAGES), .NREAD(NREAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what producer sits in each stage, and how many stall cycles were seen.
  typedef struct {
    bit v;
    int dst;
    int avail;
  } prod_t;

  prod_t m_pipe [1:STAGES];
  int    m_cnt;

  task automatic model_clear();
    for (int k = 1; k <= STAGES; k++) m_pipe[k] = '{v: 1'b0, dst: 0, avail: 0};
    m_cnt = 0;
  endtask

  // Expected select/stall from the producer list, following the forwarding rules.
  task automatic model_eval(output logic [3:0] sel, output bit stall);
    bit blk;
    int src;
    sel = '0;
    blk = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      src = int'(bus.src_D[p*5 +: 5]);
      if (bus.use_D[p] && bus.valid_D && src != 0) begin
        for (int k = 1; k <= STAGES; k++) begin
          if (m_pipe[k].v && m_pipe[k].dst == src) begin
            if (m_pipe[k].avail <= k) sel[p*2 +: 2] = 2'(k);
            else blk = 1'b1;
            break;
          end
        end
      end
    end
    stall = blk && !bus.flush;
  endtask

  task automatic set_d(input bit v, input bit [1:0] u, input int s0, input int s1,
                       input bit w, input int d, input int a);
    bus.valid_D = v;
    bus.use_D   = u;
    bus.src_D   = {5'(s1), 5'(s0)};
    bus.wr_D    = w;
    bus.dst_D   = 5'(d);
    bus.avail_D = 2'(a);
    #1;
  endtask

  // One clock edge; the model advances with the same inputs the DUT sees.
  task automatic tick();
    logic [3:0] s;
    bit st;
    int a;
    model_eval(s, st);
    @(posedge clk);
    if (bus.advance) begin
      if (st && m_cnt < 65535) m_cnt++;
      for (int k = STAGES; k >= 2; k--) m_pipe[k] = m_pipe[k-1];
      a = int'(bus.avail_D);
      if (a == 0 || a > STAGES) a = STAGES;
      if (bus.valid_D && bus.wr_D && bus.dst_D != 0 && !st && !bus.flush)
        m_pipe[1] = '{v: 1'b1, dst: int'(bus.dst_D), avail: a};
      else
        m_pipe[1] = '{v: 1'b0, dst: 0, avail: 0};
    end
    #1;
  endtask

  task automatic do_reset();
    bus.advance = 1'b1;
    bus.flush   = 1'b0;
    set_d(0, 2'b00, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_clear();
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.fwd_sel !== 4'd0 || bus.stall_D !== 1'b0 || bus.stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: fwd=%h stall=%b cnt=%0d want 0/0/0",
               bus.fwd_sel, bus.stall_D, bus.stall_cnt);
    end
    $display("reset: fwd=%h stall=%b cnt=%0d", bus.fwd_sel, bus.stall_D, bus.stall_cnt);
  endtask

  task automatic test_alu_use();
    do_reset();
    set_d(1, 2'b00, 0, 0, 1, 8, 2);
    tick();
    set_d(1, 2'b01, 8, 0, 0, 0, 2);
    total++;
    if (bus.stall_D !== 1'b1 || bus.fwd_sel[1:0] !== 2'd0) begin
      bad++;
      $display("FAIL alu_use_stall: stall=%b fwd0=%0d want 1/0", bus.stall_D, bus.fwd_sel[1:0]);
    end
    tick();
    total++;
    if (bus.stall_D !== 1'b0 || bus.fwd_sel[1:0] !== 2'd2 || bus.stall_cnt !== 16'd1) begin
      bad++;
      $display("FAIL alu_use_fwd: stall=%b fwd0=%0d cnt=%0d want 0/2/1",
               bus.stall_D, bus.fwd_sel[1:0], bus.stall_cnt);
    end
    $display("alu_use: fwd=%h stall=%b cnt=%0d", bus.fwd_sel, bus.stall_D, bus.stall_cnt);
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(1, 2'b00, 0, 0, 1, 9, 3);
    tick();
    set_d(1, 2'b10, 0, 9, 0, 0, 1);
    for (int c = 0; c < 2; c++) begin
      total++;
      if (bus.stall_D !== 1'b1) begin
        bad++;
        $display("FAIL load_use_stall%0d: stall=%b want 1", c, bus.stall_D);
      end
      tick();
    end
    total++;
    if (bus.stall_D !== 1'b0 || bus.fwd_sel[3:2] !== 2'd3 || bus.stall_cnt !== 16'd2) begin
      bad++;
      $display("FAIL load_use_fwd: stall=%b fwd1=%0d cnt=%0d want 0/3/2",
               bus.stall_D, bus.fwd_sel[3:2], bus.stall_cnt);
    end
    tick();
    total++;
    if (bus.fwd_sel[3:2] !== 2'd0 || bus.stall_cnt !== 16'd2) begin
      bad++;
      $display("FAIL load_use_retired: fwd1=%0d cnt=%0d want 0/2", bus.fwd_sel[3:2], bus.stall_cnt);
    end
    $display("load_use: fwd=%h stall=%b cnt=%0d", bus.fwd_sel, bus.stall_D, bus.stall_cnt);
  endtask

  task automatic test_jal();
    do_reset();
    set_d(1, 2'b00, 0, 0, 1, 31, 1);
    tick();
    set_d(1, 2'b11, 31, 31, 0, 0, 1);
    total++;
    if (bus.fwd_sel !== 4'b0101 || bus.stall_D !== 1'b0) begin
      bad++;
      $display("FAIL jal_fwd: fwd=%h stall=%b want 5/0", bus.fwd_sel, bus.stall_D);
    end
    $display("jal: fwd=%h stall=%b", bus.fwd_sel, bus.stall_D);
  endtask

  task automatic test_priority_zero();
    do_reset();
    set_d(1, 2'b00, 0, 0, 1, 10, 1);
    tick();
    set_d(1, 2'b00, 0, 0, 1, 10, 2);
    tick();
    set_d(0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    set_d(1, 2'b01, 10, 0, 0, 0, 1);
    total++;
    if (bus.fwd_sel[1:0] !== 2'd2 || bus.stall_D !== 1'b0) begin
      bad++;
      $display("FAIL priority_youngest: fwd0=%0d stall=%b want 2/0", bus.fwd_sel[1:0], bus.stall_D);
    end
    do_reset();
    set_d(1, 2'b00, 0, 0, 1, 0, 3);
    tick();
    set_d(1, 2'b11, 0, 0, 0, 0, 1);
    total++;
    if (bus.fwd_sel !== 4'd0 || bus.stall_D !== 1'b0) begin
      bad++;
      $display("FAIL zero_reg: fwd=%h stall=%b want 0/0", bus.fwd_sel, bus.stall_D);
    end
    // Instruction reading and writing $8: must not see itself, but must be recorded.
    do_reset();
    set_d(1, 2'b01, 8, 0, 1, 8, 2);
    total++;
    if (bus.stall_D !== 1'b0 || bus.fwd_sel !== 4'd0) begin
      bad++;
      $display("FAIL self_write: stall=%b fwd=%h want 0/0", bus.stall_D, bus.fwd_sel);
    end
    tick();
    set_d(1, 2'b01, 8, 0, 0, 0, 1);
    total++;
    if (bus.stall_D !== 1'b1) begin
      bad++;
      $display("FAIL self_write_recorded: stall=%b want 1", bus.stall_D);
    end
    $display("priority_zero: fwd=%h stall=%b", bus.fwd_sel, bus.stall_D);
  endtask

  task automatic test_freeze_flush();
    do_reset();
    set_d(1, 2'b00, 0, 0, 1, 9, 3);
    tick();
    set_d(1, 2'b01, 9, 0, 1, 12, 1);
    bus.advance = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus.stall_D !== 1'b1 || bus.stall_cnt !== 16'd0) begin
        bad++;
        $display("FAIL freeze%0d: stall=%b cnt=%0d want 1/0", c, bus.stall_D, bus.stall_cnt);
      end
    end
    bus.advance = 1'b1;
    tick();
    total++;
    if (bus.stall_D !== 1'b1 || bus.stall_cnt !== 16'd1) begin
      bad++;
      $display("FAIL freeze_release: stall=%b cnt=%0d want 1/1", bus.stall_D, bus.stall_cnt);
    end
    bus.flush = 1'b1;
    #1;
    total++;
    if (bus.stall_D !== 1'b0) begin
      bad++;
      $display("FAIL flush_wins: stall=%b want 0", bus.stall_D);
    end
    tick();
    bus.flush = 1'b0;
    set_d(1, 2'b01, 12, 0, 0, 0, 1);
    total++;
    if (bus.stall_cnt !== 16'd1 || bus.fwd_sel !== 4'd0 || bus.stall_D !== 1'b0) begin
      bad++;
      $display("FAIL flush_bubble: cnt=%0d fwd=%h stall=%b want 1/0/0",
               bus.stall_cnt, bus.fwd_sel, bus.stall_D);
    end
    set_d(1, 2'b01, 9, 0, 0, 0, 1);
    total++;
    if (bus.fwd_sel[1:0] !== 2'd3) begin
      bad++;
      $display("FAIL flush_older_kept: fwd0=%0d want 3", bus.fwd_sel[1:0]);
    end
    $display("freeze_flush: fwd=%h stall=%b cnt=%0d", bus.fwd_sel, bus.stall_D, bus.stall_cnt);
  endtask

  task automatic test_reset_midstall();
    do_reset();
    set_d(1, 2'b00, 0, 0, 1, 9, 3);
    tick();
    set_d(1, 2'b01, 9, 0, 0, 0, 1);
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.fwd_sel !== 4'd0 || bus.stall_D !== 1'b0 || bus.stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_midstall: fwd=%h stall=%b cnt=%0d want 0/0/0",
               bus.fwd_sel, bus.stall_D, bus.stall_cnt);
    end
    model_clear();
    #1;
    rst_n = 1'b1;
    #1;
    $display("reset_midstall: fwd=%h stall=%b cnt=%0d", bus.fwd_sel, bus.stall_D, bus.stall_cnt);
  endtask

  task automatic test_random();
    logic [3:0] exp_sel;
    bit exp_stall;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      bus.advance = ($urandom_range(0, 9) < 8);
      bus.flush   = ($urandom_range(0, 9) == 0);
      set_d(bit'($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
      model_eval(exp_sel, exp_stall);
      total++;
      if (bus.fwd_sel !== exp_sel || bus.stall_D !== exp_stall ||
          bus.stall_cnt !== 16'(m_cnt)) begin
        bad++;
        $display("FAIL random_%0d: fwd=%h stall=%b cnt=%0d want %h/%b/%0d",
                 n, bus.fwd_sel, bus.stall_D, bus.stall_cnt, exp_sel, exp_stall, m_cnt);
      end
      $display("rand %0d: adv=%b fl=%b src=%h fwd=%h stall=%b cnt=%0d",
               n, bus.advance, bus.flush, bus.src_D, bus.fwd_sel, bus.stall_D, bus.stall_cnt);
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.advance = 1'b1;
    bus.flush   = 1'b0;
    bus.valid_D = 1'b0;
    bus.use_D   = '0;
    bus.src_D   = '0;
    bus.wr_D    = 1'b0;
    bus.dst_D   = '0;
    bus.avail_D = '0;
    model_clear();
    #12;
    test_reset();
    test_alu_use();
    test_load_use();
    test_jal();
    test_priority_zero();
    test_freeze_flush();
    test_reset_midstall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL provide parameter STAGES, default 3, meaning tracked stages after D (1=E, 2=M, 3=W); legal range 2..6.
REQ-002 SHALL provide parameter NREAD, default 2, meaning D-stage source read ports (port 0=rs, port 1=rt).
REQ-003 SHALL define localparam SW = clog2(STAGES+1), the width of one stage index.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; clk is the clock and rst_n is the reset.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 valid_D  input  1  D holds a live instruction.
REQ-008 use_D  input  NREAD  per-port "source is read in D" flags.
REQ-009 src_D  input  NREAD*5  packed source register numbers; port i at [5i+4:5i].
REQ-010 wr_D  input  1  D instruction writes a GPR.
REQ-011 dst_D  input  5  destination register; decode supplies 31 for jal/jalr.
REQ-012 avail_D  input  SW  first stage (1..STAGES) whose pipeline register holds the result (jal=1, ALU=2, load=3).
REQ-013 advance  input  1  pipeline moves this cycle; 0 freezes the whole pipeline.
REQ-014 flush  input  1  kill the D instruction this cycle.
REQ-015 fwd_sel  output  NREAD*SW  per-port source select; 0=register file, k=stage k.
REQ-016 stall_D  output  1  hold D/F and insert a bubble into E.
REQ-017 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-018 SHALL hold STAGES entries {valid, dst[4:0], avail[SW-1:0]}; entry k mirrors the instruction in stage k.
REQ-019 On an edge with advance=1, entry k+1 SHALL take entry k and the entry leaving stage STAGES SHALL be discarded; with advance=0 all entries SHALL hold.
REQ-020 On an advancing edge, entry 1 SHALL load {1, dst_D, avail_D} only when valid_D & wr_D & dst_D!=0 & ~stall_D & ~flush; otherwise entry 1 SHALL load a bubble (valid=0).
REQ-021 An avail_D value of 0 or greater than STAGES SHALL be stored as STAGES.
REQ-022 Port i SHALL match entry k when use_D[i], valid_D, entry k valid, dst==src_i, and src_i!=0; register 0 SHALL never match.
REQ-023 Only the lowest-numbered (youngest) matching entry SHALL be considered per port.
REQ-024 If the youngest match at stage k has avail<=k, fwd_sel[i] SHALL be k; if there is no match, fwd_sel[i] SHALL be 0.
REQ-025 If the youngest match has avail>k, the port SHALL be blocked and fwd_sel[i] SHALL be 0.
REQ-026 stall_D SHALL be 1 when any port is blocked and flush=0, and SHALL be 0 otherwise.
REQ-027 stall_D and fwd_sel SHALL be combinational from the inputs and current entries, with zero-cycle latency.
REQ-028 stall_cnt SHALL increment on each edge with advance=1 & stall_D=1, and SHALL saturate at 16'hFFFF.
REQ-029 With flush=1 and stall_D would-be 1, flush SHALL win: stall_D=0, a bubble enters entry 1, and stall_cnt is unchanged.
REQ-030 An instruction writing its own source register (e.g. addi $8,$8,1) SHALL be checked against older entries only.

Reset
REQ-031 While rst_n=0, all entries SHALL be invalid, stall_cnt SHALL be 0, and therefore fwd_sel=0 and stall_D=0, independent of clk.
REQ-032 After rst_n rises, the first advancing edge SHALL behave as REQ-019/020 with no extra latency.

Verification
REQ-033 Reset: assert rst_n=0 mid-stall with entries valid -> immediately fwd_sel=0, stall_D=0, stall_cnt=0.
REQ-034 ALU-use: add $8 (avail 2), then a reader of $8 on port 0 -> exactly 1 cycle with stall_D=1, then fwd_sel[0]=2 with stall_D=0; stall_cnt=1.
REQ-035 Load-use: lw $9 (avail 3), then a reader of $9 on port 1 -> 2 stall cycles, then fwd_sel[1]=3; stall_cnt=2; the next cycle gives fwd_sel[1]=0.
REQ-036 jal: dst 31 (avail 1), then a reader of $31 on both ports -> no stall, fwd_sel={1,1}.
REQ-037 Priority/zero: $10 written at stage 2 and stage 3, read $10 -> fwd_sel=2; a write to $0 followed by a read of $0 -> fwd_sel=0, no stall.
REQ-038 Freeze/flush: advance=0 for 3 cycles during a load-use stall -> entries hold and stall_cnt is unchanged; flush=1 while blocked -> stall_D=0 and a bubble enters entry 1.
